multicycle_mem_responder: RTL and testbench

Memory-side responder for the multi-cycle CPU's memory strobe protocol. It accepts single-cycle `read_m`/`write_m` requests from the control path, holds a word-addressed 16-bit storage array, and completes each access after a fixed, parameterised latency with a one-cycle `input_ready` pulse. It replaces the bench's ad-hoc memory model and sits between the CPU datapath (address/write data from PC or ALUOut, selected by `i_or_d`) and the instruction/data registers.

---
 rtl/multicycle_mem_responder_pkg.sv | 16 +
 rtl/mem_word_array.sv | 28 ++
 rtl/multicycle_mem_responder.sv | 145 ++++++++++++++
 tb/tb_multicycle_mem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle CPU memory responder.
// Word width, countdown width and responder FSM state encodings.
package multicycle_mem_responder_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned CntBits   = 4;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemWait = 2'd1,
    MemDone = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed storage: one synchronous write port, one combinational read port.
module mem_word_array
  import multicycle_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  word_t                wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output word_t                rdata
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  word_t mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/multicycle_mem_responder.sv
// Memory-side responder for the multi-cycle CPU strobe protocol: accepts read/write
// strobes, completes each access after LATENCY cycles with a one-cycle input_ready.
module multicycle_mem_responder
  import multicycle_mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned ADDR_BITS = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 input_ready,
  output logic                 busy,
  output logic                 req_dropped,
  output logic                 req_conflict
);

  typedef logic [ADDR_BITS-1:0] addr_t;

  localparam mem_state_e AcceptState = (LATENCY == 1) ? MemDone : MemWait;

  mem_state_e         state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d;

  logic  op_write_q;
  addr_t addr_q;
  word_t wdata_q;
  word_t data_out_q;
  logic  busy_q;
  logic  dropped_q;
  logic  conflict_q;

  logic  req;
  logic  accept;
  logic  eff_write;
  addr_t eff_addr;
  logic  commit;
  logic  fwd;
  logic  load_rd;
  word_t arr_rdata;
  word_t rd_word;

  // Upper address bits alias away modulo the depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address;

  assign req    = read_m | write_m;
  assign accept = !reset && req && ((state_q == MemIdle) || (state_q == MemDone));

  // Conflicting strobes are treated as a write.
  assign eff_write = accept ? write_m : op_write_q;
  assign eff_addr  = accept ? address[ADDR_BITS-1:0] : addr_q;

  assign commit  = !reset && (state_q == MemDone) && op_write_q;
  // Only reachable when LATENCY==1: a read accepted in the write's DONE cycle sees new data.
  assign fwd     = commit && (addr_q == eff_addr);
  assign rd_word = fwd ? wdata_q : arr_rdata;
  assign load_rd = (state_d == MemDone) && !eff_write;

  mem_word_array #(
    .ADDR_BITS(ADDR_BITS),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (clk),
    .we   (commit),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(eff_addr),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MemIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MemIdle, MemDone: begin
        if (accept) begin
          state_d = AcceptState;
          cnt_d   = CntBits'(LATENCY - 1);
        end else begin
          state_d = MemIdle;
        end
      end
      MemWait: begin
        cnt_d = cnt_q - CntBits'(1);
        if (cnt_q <= CntBits'(1)) begin
          state_d = MemDone;
        end
      end
      default: state_d = MemIdle;
    endcase
    if (reset) begin
      state_d = MemIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      if (accept) begin
        op_write_q <= write_m;
        addr_q     <= address[ADDR_BITS-1:0];
        wdata_q    <= data_in;
      end
      if (load_rd) begin
        data_out_q <= rd_word;
      end
      busy_q     <= (state_d == MemWait) || ((state_d == MemDone) && !accept);
      dropped_q  <= (state_q == MemWait) && req;
      conflict_q <= accept && read_m && write_m;
    end
  end

  always_comb begin
    input_ready  = (state_q == MemDone);
    busy         = busy_q;
    data_out     = data_out_q;
    req_dropped  = dropped_q;
    req_conflict = conflict_q;
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Scoreboard bench: stimulus pushes expected completions (cycle, data_out) into a
// queue per responder; monitors pop and compare on every input_ready pulse.
module tb_multicycle_mem_responder;

  typedef struct {
    int          cyc;
    logic [15:0] dout;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t q1[$];
  exp_t q3[$];
  logic [15:0] exp_dout1 = '0;
  logic [15:0] exp_dout3 = '0;

  logic        rst1, rd1, wr1;
  logic [15:0] addr1, din1, dout1;
  logic        ir1, busy1, drop1, conf1;

  logic        rst3, rd3, wr3;
  logic [15:0] addr3, din3, dout3;
  logic        ir3, busy3, drop3, conf3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) u_dut1 (
    .clk(clk), .reset(rst1), .read_m(rd1), .write_m(wr1), .address(addr1), .data_in(din1),
    .data_out(dout1), .input_ready(ir1), .busy(busy1), .req_dropped(drop1),
    .req_conflict(conf1)
  );

  multicycle_mem_responder #(.LATENCY(3), .ADDR_BITS(8)) u_dut3 (
    .clk(clk), .reset(rst3), .read_m(rd3), .write_m(wr3), .address(addr3), .data_in(din3),
    .data_out(dout3), .input_ready(ir3), .busy(busy3), .req_dropped(drop3),
    .req_conflict(conf3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ir1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL d1 spurious input_ready at cycle %0d: got 1, expected 0", cyc);
      end else begin
        e = q1.pop_front();
        check({e.name, " completion cycle"}, cyc, e.cyc);
        check({e.name, " data_out"}, {16'h0, dout1}, {16'h0, e.dout});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ir3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL d3 spurious input_ready at cycle %0d: got 1, expected 0", cyc);
      end else begin
        e = q3.pop_front();
        check({e.name, " completion cycle"}, cyc, e.cyc);
        check({e.name, " data_out"}, {16'h0, dout3}, {16'h0, e.dout});
      end
    end
  end

  // Each step holds one cycle's inputs, set just after the rising edge.
  task automatic step1(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d);
    @(posedge clk); #1;
    rd1 = rd; wr1 = wr; addr1 = a; din1 = d;
  endtask

  task automatic step3(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d);
    @(posedge clk); #1;
    rd3 = rd; wr3 = wr; addr3 = a; din3 = d;
  endtask

  task automatic idle3(input int n);
    for (int i = 0; i < n; i++) step3(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic push1(input logic is_rd, input logic [15:0] d, input string name);
    if (is_rd) exp_dout1 = d;
    q1.push_back('{cyc: cyc + 1, dout: exp_dout1, name: name});
  endtask

  task automatic push3(input logic is_rd, input logic [15:0] d, input string name);
    if (is_rd) exp_dout3 = d;
    q3.push_back('{cyc: cyc + 3, dout: exp_dout3, name: name});
  endtask

  task automatic check_zero3(input string tag);
    check({tag, " data_out"}, {16'h0, dout3}, 32'h0);
    check({tag, " input_ready"}, {31'h0, ir3}, 32'h0);
    check({tag, " busy"}, {31'h0, busy3}, 32'h0);
    check({tag, " req_dropped"}, {31'h0, drop3}, 32'h0);
    check({tag, " req_conflict"}, {31'h0, conf3}, 32'h0);
  endtask

  initial begin
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    rst3 = 1'b1; rd3 = 1'b0; wr3 = 1'b0; addr3 = '0; din3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    check_zero3("d3 reset");
    check("d1 reset data_out", {16'h0, dout1}, 32'h0);
    check("d1 reset busy", {31'h0, busy1}, 32'h0);
    check("d1 reset input_ready", {31'h0, ir1}, 32'h0);

    // LATENCY=1: preload then read; busy low two cycles after the read.
    step1(1'b0, 1'b1, 16'h0010, 16'h1234); push1(1'b0, 16'h0, "d1 preload write");
    step1(1'b0, 1'b0, 16'h0, 16'h0);
    step1(1'b1, 1'b0, 16'h0010, 16'h0);    push1(1'b1, 16'h1234, "d1 read 0x10");
    step1(1'b0, 1'b0, 16'h0, 16'h0);
    step1(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("d1 busy after read", {31'h0, busy1}, 32'h0);

    // LATENCY=1: read accepted in the write's DONE cycle returns the new data.
    step1(1'b0, 1'b1, 16'h0011, 16'h0A0A); push1(1'b0, 16'h0, "d1 raw write");
    step1(1'b1, 1'b0, 16'h0011, 16'h0);    push1(1'b1, 16'h0A0A, "d1 raw read");
    step1(1'b0, 1'b0, 16'h0, 16'h0);
    step1(1'b0, 1'b0, 16'h0, 16'h0);

    // LATENCY=3: write then read accepted in the write's DONE cycle.
    step3(1'b0, 1'b1, 16'h0005, 16'hBEEF); push3(1'b0, 16'h0, "d3 write 0x05");
    idle3(1);
    @(negedge clk);
    check("d3 busy in wait", {31'h0, busy3}, 32'h1);
    idle3(1);
    step3(1'b1, 1'b0, 16'h0005, 16'h0);    push3(1'b1, 16'hBEEF, "d3 read 0x05");
    idle3(4);

    // Drop while busy.
    step3(1'b1, 1'b0, 16'h0005, 16'h0);    push3(1'b1, 16'hBEEF, "d3 read before drop");
    step3(1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    check("d3 req_dropped after accept", {31'h0, drop3}, 32'h0);
    idle3(1);
    @(negedge clk);
    check("d3 req_dropped", {31'h0, drop3}, 32'h1);
    idle3(1);
    @(negedge clk);
    check("d3 req_dropped clears", {31'h0, drop3}, 32'h0);
    idle3(1);

    // Conflict treated as write; data_out unchanged by it.
    step3(1'b1, 1'b1, 16'h0007, 16'h00AA); push3(1'b0, 16'h0, "d3 conflict write");
    idle3(1);
    @(negedge clk);
    check("d3 req_conflict", {31'h0, conf3}, 32'h1);
    idle3(1);
    @(negedge clk);
    check("d3 req_conflict clears", {31'h0, conf3}, 32'h0);
    idle3(2);
    step3(1'b1, 1'b0, 16'h0007, 16'h0);    push3(1'b1, 16'h00AA, "d3 read 0x07");
    idle3(3);

    // Aliasing modulo 256 words.
    step3(1'b0, 1'b1, 16'h0103, 16'h5555); push3(1'b0, 16'h0, "d3 write 0x103");
    idle3(3);
    step3(1'b1, 1'b0, 16'h0003, 16'h0);    push3(1'b1, 16'h5555, "d3 alias read 0x03");
    idle3(3);

    // Reset mid-write: write discarded, request during reset ignored.
    step3(1'b0, 1'b1, 16'h0020, 16'h1111); push3(1'b0, 16'h0, "d3 write 0x20 old");
    idle3(3);
    step3(1'b0, 1'b1, 16'h0020, 16'h9999);
    idle3(1);
    @(posedge clk); #1;
    rst3 = 1'b1; rd3 = 1'b1; wr3 = 1'b0; addr3 = 16'h0005;
    @(posedge clk); #1;
    rst3 = 1'b0; rd3 = 1'b0;
    exp_dout3 = 16'h0;
    @(negedge clk);
    check_zero3("d3 after reset");
    idle3(4);
    step3(1'b1, 1'b0, 16'h0020, 16'h0);    push3(1'b1, 16'h1111, "d3 read 0x20 after reset");
    idle3(3);

    for (int i = 0; i < 20 && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    while (q1.size() != 0) begin
      n_checks++;
      $display("FAIL %s: got no input_ready, expected one at cycle %0d", q1[0].name, q1[0].cyc);
      void'(q1.pop_front());
    end
    while (q3.size() != 0) begin
      n_checks++;
      $display("FAIL %s: got no input_ready, expected one at cycle %0d", q3[0].name, q3[0].cyc);
      void'(q3.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
